// File: rtl/demux_pkg.sv
// Shared constants and encodings for the 1-to-2 registered demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // Destination select encoding
    typedef enum logic {
        SEL_OUT1 = 1'b0,
        SEL_OUT2 = 1'b1
    } sel_e;

    // One-entry holding slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/demux_1_2_if.sv
// Handshake bundle for demux_1_2: one input stream, two output streams.
// slave is the demux side, master is the producer/consumer side.
interface demux_1_2_if
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;

    modport slave (
        input  in_data, in_sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/demux_1_2_slot.sv
// One-entry output holding register for the demux. Drain and refill in the
// same cycle keeps the slot full with the new word (no bubble).
// Optional delivered-word counter guarded by DEMUX_COUNT_EN.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);
    slot_e state;

    assign valid      = (state == SLOT_FULL);
    // Free now, or freed by the drain happening this very cycle
    assign can_accept = (state == SLOT_EMPTY) || ready;

    // Occupancy and data: load wins over drain; data kept when slot empties
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
        end else if (valid && ready) begin
            state <= SLOT_EMPTY;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Count each word handed to the consumer; wraps naturally
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (valid && ready)
            cnt <= cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/demux_1_2.sv
// Registered 1-to-2 demux with valid/ready handshaking. Each output has a
// one-entry holding slot; the top only sanitises the select and generates
// in_ready. Define DEMUX_COUNT_EN for per-output delivered-word counters.
module demux_1_2
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    demux_1_2_if.slave       bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
`endif
);
    sel_e sel;
    logic acc1, acc2;
    logic xfer;

    // Only an explicit 1 routes to output 2; X/Z fall through to output 1
    always_comb begin
        sel = SEL_OUT1;
        if (bus.in_sel == 1'b1)
            sel = SEL_OUT2;
    end

    // Ready depends only on the selected slot, never on in_valid
    assign bus.in_ready = (sel == SEL_OUT2) ? acc2 : acc1;
    assign xfer         = bus.in_valid && bus.in_ready;

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (xfer && (sel == SEL_OUT1)),
        .load_data  (bus.in_data),
        .ready      (bus.out1_ready),
        .valid      (bus.out1_valid),
        .data       (bus.out1_data),
        .can_accept (acc1)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt        (cnt1)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_slot2 (
        .clk        (clk),
        .rst        (rst),
        .load       (xfer && (sel == SEL_OUT2)),
        .load_data  (bus.in_data),
        .ready      (bus.out2_ready),
        .valid      (bus.out2_valid),
        .data       (bus.out2_data),
        .can_accept (acc2)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt        (cnt2)
`endif
    );

endmodule

// File: tb/tb_demux_1_2.sv
// Directed self-checking bench for demux_1_2. Counter checks are compiled
// in when DEMUX_COUNT_EN is defined (counters built 4 bits wide here).
module tb_demux_1_2;
    localparam int W     = 32;
    localparam int TCW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_c1 = 0;
    int   exp_c2 = 0;

`ifdef DEMUX_COUNT_EN
    logic [TCW-1:0] cnt1, cnt2;
`endif

    demux_1_2_if #(.WIDTH(W)) bus ();

    demux_1_2 #(
        .WIDTH (W)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W (TCW)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt1 (cnt1),
        .cnt2 (cnt2)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        // Intentionally unused: each scenario compares inline.
    endtask

    task automatic check_cnt(input string name);
`ifdef DEMUX_COUNT_EN
        checks++;
        if (cnt1 !== TCW'(exp_c1)) begin
            errors++;
            $display("FAIL %s cnt1 got=%0d want=%0d", name, cnt1, exp_c1 % 16);
        end
        checks++;
        if (cnt2 !== TCW'(exp_c2)) begin
            errors++;
            $display("FAIL %s cnt2 got=%0d want=%0d", name, cnt2, exp_c2 % 16);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_data = '0; bus.in_sel = 1'b0; bus.in_valid = 1'b0;
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
        step; step;
        rst = 1'b0;
        checks++; if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL reset out1_valid got=%b want=0", bus.out1_valid); end
        checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL reset out2_valid got=%b want=0", bus.out2_valid); end
        checks++; if (bus.out1_data !== 32'h0) begin errors++; $display("FAIL reset out1_data got=%h want=0", bus.out1_data); end
        checks++; if (bus.out2_data !== 32'h0) begin errors++; $display("FAIL reset out2_data got=%h want=0", bus.out2_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b want=1", bus.in_ready); end
        exp_c1 = 0; exp_c2 = 0;
        check_cnt("reset");
    endtask

    task automatic test_stall_out1;
        bus.in_sel = 1'b0; bus.in_data = 32'hDEADBEEF; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall first_ready got=%b want=1", bus.in_ready); end
        step;
        checks++; if (bus.out1_valid !== 1'b1) begin errors++; $display("FAIL stall out1_valid got=%b want=1", bus.out1_valid); end
        checks++; if (bus.out1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stall out1_data got=%h want=deadbeef", bus.out1_data); end
        checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL stall out2_valid got=%b want=0", bus.out2_valid); end
        bus.in_data = 32'h11111111;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall blocked_ready got=%b want=0", bus.in_ready); end
        step;
        checks++; if (bus.out1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stall held_data got=%h want=deadbeef", bus.out1_data); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_other_slot;
        bus.in_sel = 1'b1; bus.in_data = 32'h12345678; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL other in_ready got=%b want=1", bus.in_ready); end
        step;
        bus.in_valid = 1'b0;
        checks++; if (bus.out2_valid !== 1'b1) begin errors++; $display("FAIL other out2_valid got=%b want=1", bus.out2_valid); end
        checks++; if (bus.out2_data !== 32'h12345678) begin errors++; $display("FAIL other out2_data got=%h want=12345678", bus.out2_data); end
        checks++; if (bus.out1_valid !== 1'b1) begin errors++; $display("FAIL other out1_valid got=%b want=1", bus.out1_valid); end
        checks++; if (bus.out1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL other out1_data got=%h want=deadbeef", bus.out1_data); end
        // drain both slots in the same cycle
        bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
        step;
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
        exp_c1++; exp_c2++;
        checks++; if ({bus.out1_valid, bus.out2_valid} !== 2'b00) begin errors++; $display("FAIL other drained got=%b want=00", {bus.out1_valid, bus.out2_valid}); end
        check_cnt("other");
    endtask

    task automatic test_stream;
        logic [W-1:0] word;
        bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            word = 32'h100 + W'(i);
            bus.in_sel = i[0]; bus.in_data = word; bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream ready[%0d] got=%b want=1", i, bus.in_ready); end
            step;
            if (i[0] == 1'b0) begin
                checks++;
                if (bus.out1_valid !== 1'b1 || bus.out1_data !== word) begin
                    errors++; $display("FAIL stream out1[%0d] got=%b/%h want=1/%h", i, bus.out1_valid, bus.out1_data, word);
                end
            end else begin
                checks++;
                if (bus.out2_valid !== 1'b1 || bus.out2_data !== word) begin
                    errors++; $display("FAIL stream out2[%0d] got=%b/%h want=1/%h", i, bus.out2_valid, bus.out2_data, word);
                end
            end
        end
        bus.in_valid = 1'b0;
        step;
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
        exp_c1 += 4; exp_c2 += 4;
        checks++; if ({bus.out1_valid, bus.out2_valid} !== 2'b00) begin errors++; $display("FAIL stream empty got=%b want=00", {bus.out1_valid, bus.out2_valid}); end
        check_cnt("stream");
    endtask

    task automatic test_drain_refill;
        bus.in_sel = 1'b0; bus.in_data = 32'h0BAD0001; bus.in_valid = 1'b1;
        step;
        bus.out1_ready = 1'b1; bus.in_data = 32'hA5A5A5A5;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL refill in_ready got=%b want=1", bus.in_ready); end
        step;
        bus.in_valid = 1'b0; bus.out1_ready = 1'b0;
        exp_c1++;
        checks++; if (bus.out1_valid !== 1'b1) begin errors++; $display("FAIL refill out1_valid got=%b want=1", bus.out1_valid); end
        checks++; if (bus.out1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL refill out1_data got=%h want=a5a5a5a5", bus.out1_data); end
        check_cnt("refill");
        bus.out1_ready = 1'b1;
        step;
        bus.out1_ready = 1'b0;
        exp_c1++;
        checks++; if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL refill drained got=%b want=0", bus.out1_valid); end
    endtask

    task automatic test_x_sel;
        bus.in_sel = 1'bx; bus.in_data = 32'h0000CAFE; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL xsel in_ready got=%b want=1", bus.in_ready); end
        step;
        bus.in_valid = 1'b0; bus.in_sel = 1'b0;
        checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h0000CAFE) begin errors++; $display("FAIL xsel out1 got=%b/%h want=1/0000cafe", bus.out1_valid, bus.out1_data); end
        checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL xsel out2_valid got=%b want=0", bus.out2_valid); end
        bus.out1_ready = 1'b1;
        step;
        bus.out1_ready = 1'b0;
        exp_c1++;
        check_cnt("xsel");
    endtask

    task automatic test_reset_mid;
        bus.in_sel = 1'b0; bus.in_data = 32'h0000AAAA; bus.in_valid = 1'b1;
        step;
        bus.in_sel = 1'b1; bus.in_data = 32'h0000BBBB;
        step;
        checks++; if ({bus.out1_valid, bus.out2_valid} !== 2'b11) begin errors++; $display("FAIL rstmid both_full got=%b want=11", {bus.out1_valid, bus.out2_valid}); end
        // reset while a drain and a refill are both requested
        rst = 1'b1; bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
        step;
        rst = 1'b0; bus.in_valid = 1'b0; bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
        exp_c1 = 0; exp_c2 = 0;
        #1;
        checks++; if ({bus.out1_valid, bus.out2_valid} !== 2'b00) begin errors++; $display("FAIL rstmid valids got=%b want=00", {bus.out1_valid, bus.out2_valid}); end
        checks++; if (bus.out1_data !== 32'h0 || bus.out2_data !== 32'h0) begin errors++; $display("FAIL rstmid data got=%h/%h want=0/0", bus.out1_data, bus.out2_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid in_ready got=%b want=1", bus.in_ready); end
        check_cnt("rstmid");
    endtask

    task automatic test_cnt_wrap;
`ifdef DEMUX_COUNT_EN
        bus.out2_ready = 1'b1; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = 32'h200 + W'(i);
            step;
        end
        bus.in_valid = 1'b0;
        step;
        bus.out2_ready = 1'b0;
        // 17 drains into a 4-bit counter wraps to 1
        checks++; if (cnt2 !== 4'd1) begin errors++; $display("FAIL wrap cnt2 got=%0d want=1", cnt2); end
        checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL wrap cnt1 got=%0d want=0", cnt1); end
`endif
    endtask

    initial begin
        test_reset;
        test_stall_out1;
        test_other_slot;
        test_stream;
        test_drain_refill;
        test_x_sel;
        test_reset_mid;
        test_cnt_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
